// File: rtl/spike_out_scheduler.sv
// Moves per-timestep spike vectors from the neuron core into the spike SRAM,
// yielding to host Wishbone traffic and double-buffering one batch while the host catches up.
module spike_out_scheduler #(
    parameter int TS_W = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            core_done_i,
    input  logic [255:0]    core_spike_i,
    output logic            core_ready_o,
    input  logic            bus_busy_i,
    output logic [255:0]    ext_spike_data_o,
    output logic            ext_write_en_o,
    input  logic            host_clear_i,
    output logic            irq_o,
    input  logic            overflow_clr_i,
    output logic            overflow_o,
    output logic [TS_W-1:0] timestep_cnt_o,
    output logic [1:0]      state_dbg_o
);

    // Handshake: core_done_i is a one-cycle strobe that is never back-pressured;
    // core_ready_o only advertises whether the next strobe would be kept or dropped.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BUS = 2'd1,
        COMMIT   = 2'd2,
        READY    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [255:0]     shadow;
    logic [255:0]     pending;
    logic             pend_v;
    logic             overflow;
    logic [TS_W-1:0]  ts_cnt;

    logic             clear_fire;
    logic             shadow_load;
    logic [255:0]     shadow_d;
    logic             pend_load;
    logic             pend_v_nxt;
    logic             ovf_set;
    logic             cnt_inc;

    assign clear_fire = (state == READY) && host_clear_i;
    assign cnt_inc    = (state == COMMIT) && !bus_busy_i;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (core_done_i) state_nxt = WAIT_BUS;
            WAIT_BUS: if (!bus_busy_i) state_nxt = COMMIT;
            COMMIT:   if (!bus_busy_i) state_nxt = READY;
            READY: begin
                if (host_clear_i) begin
                    state_nxt = (pend_v || core_done_i) ? WAIT_BUS : IDLE;
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // A host clear frees the shadow, so a coincident core vector never overflows there.
    always_comb begin
        shadow_load = 1'b0;
        shadow_d    = pending;
        pend_load   = 1'b0;
        pend_v_nxt  = pend_v;
        ovf_set     = 1'b0;
        if (state == IDLE) begin
            if (core_done_i) begin
                shadow_load = 1'b1;
                shadow_d    = core_spike_i;
            end
        end else if (clear_fire) begin
            if (pend_v) begin
                shadow_load = 1'b1;
                shadow_d    = pending;
                if (core_done_i) pend_load = 1'b1;
                else             pend_v_nxt = 1'b0;
            end else if (core_done_i) begin
                shadow_load = 1'b1;
                shadow_d    = core_spike_i;
            end
        end else if (core_done_i) begin
            if (pend_v) begin
                ovf_set = 1'b1;
            end else begin
                pend_load  = 1'b1;
                pend_v_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            shadow   <= '0;
            pending  <= '0;
            pend_v   <= 1'b0;
            overflow <= 1'b0;
            ts_cnt   <= '0;
        end else begin
            state  <= state_nxt;
            pend_v <= pend_v_nxt;
            if (shadow_load) shadow  <= shadow_d;
            if (pend_load)   pending <= core_spike_i;
            if (cnt_inc)     ts_cnt  <= ts_cnt + 1'b1;
            if (ovf_set)             overflow <= 1'b1;
            else if (overflow_clr_i) overflow <= 1'b0;
        end
    end

    assign core_ready_o     = ~pend_v;
    assign ext_spike_data_o = shadow;
    assign ext_write_en_o   = (state == COMMIT);
    assign irq_o            = (state == READY);
    assign overflow_o       = overflow;
    assign timestep_cnt_o   = ts_cnt;
    assign state_dbg_o      = state;

endmodule

// File: tb/tb_spike_out_scheduler.sv
// Bench for spike_out_scheduler: directed scenarios plus random traffic checked
// against a batch-queue model of the scheduler.
module tb_spike_out_scheduler;

    localparam int TS_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            core_done_i = 1'b0;
    logic [255:0]    core_spike_i = '0;
    logic            core_ready_o;
    logic            bus_busy_i = 1'b0;
    logic [255:0]    ext_spike_data_o;
    logic            ext_write_en_o;
    logic            host_clear_i = 1'b0;
    logic            irq_o;
    logic            overflow_clr_i = 1'b0;
    logic            overflow_o;
    logic [TS_W-1:0] timestep_cnt_o;
    logic [1:0]      state_dbg_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model: queue of batches, front = batch in flight (shadow), second = pending.
    // stage of the front batch: 0 waiting for bus, 1 being written, 2 written, awaiting host.
    logic [255:0]    exp_q[$];
    int              stage;
    logic [TS_W-1:0] exp_cnt;
    logic            exp_ovf;
    logic [255:0]    exp_data;

    spike_out_scheduler #(.TS_W(TS_W)) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .core_done_i     (core_done_i),
        .core_spike_i    (core_spike_i),
        .core_ready_o    (core_ready_o),
        .bus_busy_i      (bus_busy_i),
        .ext_spike_data_o(ext_spike_data_o),
        .ext_write_en_o  (ext_write_en_o),
        .host_clear_i    (host_clear_i),
        .irq_o           (irq_o),
        .overflow_clr_i  (overflow_clr_i),
        .overflow_o      (overflow_o),
        .timestep_cnt_o  (timestep_cnt_o),
        .state_dbg_o     (state_dbg_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        stage    = 0;
        exp_cnt  = '0;
        exp_ovf  = 1'b0;
        exp_data = '0;
    endtask

    task automatic model_step(input logic done, input logic [255:0] spk, input logic busy,
                              input logic clr, input logic oclr);
        int  old_size;
        logic set_ovf;
        old_size = exp_q.size();
        set_ovf  = 1'b0;
        if (old_size > 0) begin
            case (stage)
                0: if (!busy) stage = 1;
                1: if (!busy) begin stage = 2; exp_cnt = exp_cnt + 1'b1; end
                default: if (clr) begin void'(exp_q.pop_front()); stage = 0; end
            endcase
        end
        if (done) begin
            if (exp_q.size() < 2) exp_q.push_back(spk);
            else                  set_ovf = 1'b1;
        end
        if (set_ovf)   exp_ovf = 1'b1;
        else if (oclr) exp_ovf = 1'b0;
        if (exp_q.size() > 0) exp_data = exp_q[0];
    endtask

    task automatic check_outputs();
        logic has;
        has = (exp_q.size() > 0);
        check_val("write_en",   {255'b0, ext_write_en_o}, {255'b0, has && stage == 1});
        check_val("irq",        {255'b0, irq_o},          {255'b0, has && stage == 2});
        check_val("core_ready", {255'b0, core_ready_o},   {255'b0, exp_q.size() < 2});
        check_val("overflow",   {255'b0, overflow_o},     {255'b0, exp_ovf});
        check_val("ts_cnt",     {{(256-TS_W){1'b0}}, timestep_cnt_o}, {{(256-TS_W){1'b0}}, exp_cnt});
        check_val("spike_data", ext_spike_data_o,         exp_data);
    endtask

    task automatic drive_cycle(input logic done, input logic [255:0] spk, input logic busy,
                               input logic clr, input logic oclr);
        core_done_i    = done;
        core_spike_i   = spk;
        bus_busy_i     = busy;
        host_clear_i   = clr;
        overflow_clr_i = oclr;
        @(posedge clk);
        model_step(done, spk, busy, clr, oclr);
        #1;
        check_outputs();
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        core_done_i = 1'b0; bus_busy_i = 1'b0; host_clear_i = 1'b0; overflow_clr_i = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // Single batch on an idle bus: strobe in cycle 2, irq in cycle 3.
        drive_cycle(1'b1, 256'h1, 1'b0, 1'b0, 1'b0);
        check_val("c1_write_en", {255'b0, ext_write_en_o}, 256'h0);
        idle_cycle();
        check_val("c2_write_en", {255'b0, ext_write_en_o}, 256'h1);
        check_val("c2_data", ext_spike_data_o, 256'h1);
        idle_cycle();
        check_val("c3_write_en", {255'b0, ext_write_en_o}, 256'h0);
        check_val("c3_irq", {255'b0, irq_o}, 256'h1);
        check_val("c3_cnt", {{(256-TS_W){1'b0}}, timestep_cnt_o}, 256'h1);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Host holds the bus for five cycles, then re-grabs it mid-strobe.
        drive_cycle(1'b1, 256'h55, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check_val("busy_hold_we", {255'b0, ext_write_en_o}, 256'h0);
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_val("busy_release_we", {255'b0, ext_write_en_o}, 256'h1);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_val("busy_extend_we", {255'b0, ext_write_en_o}, 256'h1);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_val("busy_done_irq", {255'b0, irq_o}, 256'h1);

        // Three batches before the host reacts: B pends, C drops.
        apply_reset();
        drive_cycle(1'b1, 256'hA, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 256'hB, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 256'hC, 1'b0, 1'b0, 1'b0);
        check_val("ovf_set", {255'b0, overflow_o}, 256'h1);
        check_val("ovf_ready", {255'b0, core_ready_o}, 256'h0);
        idle_cycle();
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check_val("b_shadow", ext_spike_data_o, 256'hB);
        idle_cycle();
        idle_cycle();
        check_val("b_cnt", {{(256-TS_W){1'b0}}, timestep_cnt_o}, 256'h2);

        // Clear and a new vector together while another batch pends.
        drive_cycle(1'b1, 256'hE, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 256'hD, 1'b0, 1'b1, 1'b0);
        check_val("swap_shadow", ext_spike_data_o, 256'hE);
        check_val("swap_ready", {255'b0, core_ready_o}, 256'h0);
        check_val("swap_ovf", {255'b0, overflow_o}, 256'h1);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_val("ovf_cleared", {255'b0, overflow_o}, 256'h0);
        idle_cycle();
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check_val("d_shadow", ext_spike_data_o, 256'hD);
        idle_cycle();
        idle_cycle();
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive_cycle($urandom_range(0, 3) == 0, rand_vec(), $urandom_range(0, 2) == 0,
                        $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        end

        // Counter wrap: commit until all-ones, then one more.
        apply_reset();
        begin
            int guard;
            guard = 0;
            while (exp_cnt != {TS_W{1'b1}} && guard < 300) begin
                drive_cycle(1'b1, rand_vec(), 1'b0, 1'b0, 1'b0);
                idle_cycle();
                idle_cycle();
                drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
                guard++;
            end
            check_val("wrap_budget", {255'b0, guard >= 300}, 256'h0);
        end
        drive_cycle(1'b1, 256'h77, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        idle_cycle();
        check_val("wrap_zero", {{(256-TS_W){1'b0}}, timestep_cnt_o}, 256'h0);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a strobe.
        drive_cycle(1'b1, 256'h99, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        check_val("pre_rst_we", {255'b0, ext_write_en_o}, 256'h1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_val("rst_we", {255'b0, ext_write_en_o}, 256'h0);
        check_val("rst_data", ext_spike_data_o, 256'h0);
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_cycle(1'b1, 256'h3, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        idle_cycle();
        check_val("post_rst_cnt", {{(256-TS_W){1'b0}}, timestep_cnt_o}, 256'h1);
        check_val("post_rst_data", ext_spike_data_o, 256'h3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spike_out_scheduler.md
SPIKE_OUT_SCHEDULER -- requirements
Module: spike_out_scheduler

Interface
REQ-001 SHALL have parameter TS_W, default 16, width of the timestep counter.
REQ-002 SHALL have port wb_clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port core_done_i  input  1  one-cycle pulse: neuron core finished a timestep.
REQ-005 SHALL have port core_spike_i  input  256  spike vector, valid with core_done_i.
REQ-006 SHALL have port core_ready_o  output  1  high when a core_done_i can be accepted without loss.
REQ-007 SHALL have port bus_busy_i  input  1  Wishbone cycle active on spike SRAM (cyc AND stb).
REQ-008 SHALL have port ext_spike_data_o  output  256  data driven to spike SRAM external port.
REQ-009 SHALL have port ext_write_en_o  output  1  external write strobe to spike SRAM.
REQ-010 SHALL have port host_clear_i  input  1  host pulse: committed batch consumed.
REQ-011 SHALL have port irq_o  output  1  new spike batch committed, awaiting host.
REQ-012 SHALL have port overflow_clr_i  input  1  clears overflow_o.
REQ-013 SHALL have port overflow_o  output  1  sticky: a batch was dropped.
REQ-014 SHALL have port timestep_cnt_o  output  TS_W  count of committed batches.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_BUS, COMMIT, READY.
REQ-016 SHALL hold a 256-bit shadow register (drives ext_spike_data_o) and one 256-bit pending buffer with valid flag pend_v.
REQ-017 IDLE: on core_done_i, SHALL latch core_spike_i into shadow and go WAIT_BUS next cycle.
REQ-018 WAIT_BUS: SHALL stay while bus_busy_i=1; go COMMIT on first cycle bus_busy_i=0 (host access has priority, no timeout).
REQ-019 COMMIT: ext_write_en_o SHALL be 1 (combinational from state, 0 in all other states); stays COMMIT while bus_busy_i=1 at edge; bus_busy_i=0 at edge -> READY.
REQ-020 COMMIT->READY transition SHALL increment timestep_cnt_o by 1, modulo 2^TS_W (wraps all-ones -> 0).
REQ-021 irq_o SHALL be 1 exactly while state=READY.
REQ-022 READY: on host_clear_i, SHALL go WAIT_BUS with shadow<=pending if pend_v=1 (pend_v cleared same edge), else IDLE.
REQ-023 core_done_i while state!=IDLE and pend_v=0 SHALL store core_spike_i into pending, set pend_v.
REQ-024 core_done_i while state!=IDLE and pend_v=1 SHALL drop the new vector and set overflow_o; pending unchanged.
REQ-025 Simultaneous host_clear_i and core_done_i in READY, pend_v=1: SHALL move old pending to shadow and store new vector in pending (pend_v stays 1), no overflow.
REQ-026 Same case with pend_v=0: SHALL load new vector directly to shadow, go WAIT_BUS, pend_v stays 0.
REQ-027 core_ready_o SHALL equal NOT pend_v.
REQ-028 host_clear_i outside READY SHALL be ignored.
REQ-029 overflow_clr_i SHALL clear overflow_o; if a set event coincides, set wins.
REQ-030 ext_spike_data_o SHALL change only on shadow loads, never during COMMIT.

Reset
REQ-031 wb_rst_i SHALL immediately force state=IDLE, shadow=0, pending=0, pend_v=0, overflow_o=0, timestep_cnt_o=0; thus irq_o=0, ext_write_en_o=0, core_ready_o=1.
REQ-032 Reset mid-COMMIT SHALL deassert ext_write_en_o asynchronously; no increment, batch discarded.

Verification
REQ-033 Idle bus: core_done_i with spikes=256'h1 -> ext_write_en_o high cycle 2 for one cycle, data 256'h1, irq_o high cycle 3, timestep_cnt_o=1.
REQ-034 bus_busy_i held 5 cycles after core_done_i -> ext_write_en_o stays 0 until bus_busy_i low, then one-cycle strobe; busy raised during COMMIT extends strobe.
REQ-035 Three core_done_i (A,B,C) before host_clear_i -> B pending, C dropped, overflow_o=1, core_ready_o=0; host_clear_i -> B committed, cnt=2.
REQ-036 host_clear_i and core_done_i(D) same cycle in READY with B pending -> B committed next, D pending, overflow_o unchanged.
REQ-037 Preload timestep_cnt_o to 16'hFFFF via 65535 commits -> next commit gives 0.
REQ-038 wb_rst_i asserted during COMMIT -> all outputs at reset values same cycle; following core_done_i processed normally with cnt=1.
